// File: rtl/power_seq_pkg.sv
// Shared definitions for the power-rail sequencer: widths, FSM state
// encoding and a saturating counter helper.
package power_seq_pkg;

    // Width of the step-delay / power-good timeout counter.
    localparam int CNT_W = 16;

    // Width of the rail index (supports up to 8 rails).
    localparam int IDX_W = 3;

    // FSM state encoding, kept as plain constants so the encoding stays
    // visible in legacy waveform viewers and netlists.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_UP_DLY  = 3'd1;
    localparam state_t ST_UP_WAIT = 3'd2;
    localparam state_t ST_ON      = 3'd3;
    localparam state_t ST_DN_DLY  = 3'd4;
    localparam state_t ST_FAULT   = 3'd5;

    // Down-count that sticks at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

endpackage

// File: rtl/seq_sync2.sv
// Two-flop synchroniser for level signals crossing into the sequencer
// clock domain. Each bit is synchronised independently; multi-bit inputs
// are treated as unrelated levels, not as a coherent bus.
module seq_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Capture stage followed by the settling stage; both clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so meta and q both update from
            // pre-edge values; blocking here would collapse the two flops.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/power_seq_ctrl.sv
// Power-rail sequencer. Enables rails 0..NUM_RAILS-1 in order, spacing
// each enable by STEP_DLY cycles and requiring each rail's power-good
// within PG_TIMEOUT cycles before moving on. Power-down walks the rails
// in reverse with the same spacing. Any timeout or loss of power-good
// drops every rail at once and latches a fault until the request is
// withdrawn.
module power_seq_ctrl
    import power_seq_pkg::*;
#(
    parameter int               NUM_RAILS  = 4,
    parameter logic [CNT_W-1:0] STEP_DLY   = 16'd2500,
    parameter logic [CNT_W-1:0] PG_TIMEOUT = 16'd25000
) (
    input  logic                 SYSCLK,
    input  logic                 RESET,
    input  logic                 PWR_ON_REQ,
    input  logic [NUM_RAILS-1:0] RAIL_PG,
    output logic [NUM_RAILS-1:0] RAIL_EN,
    output logic                 SEQ_DONE,
    output logic                 SEQ_FAULT,
    output logic [IDX_W-1:0]     FAULT_RAIL
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

    // Synchronised views of the asynchronous inputs; the FSM uses only these.
    logic                 req_s;
    logic [NUM_RAILS-1:0] pg_s;

    // Registered FSM state.
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    // Next-state values.
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic [NUM_RAILS-1:0] en_nxt;
    logic [IDX_W-1:0]     fault_rail_nxt;

    // Power-good decode.
    logic             pg_cur;   // power-good of the rail selected by idx
    logic             pg_all;   // every rail reports good
    logic [IDX_W-1:0] low_idx;  // lowest rail not reporting good

    seq_sync2 #(.W(1)) u_req_sync (
        .clk (SYSCLK),
        .rst (RESET),
        .d   (PWR_ON_REQ),
        .q   (req_s)
    );

    seq_sync2 #(.W(NUM_RAILS)) u_pg_sync (
        .clk (SYSCLK),
        .rst (RESET),
        .d   (RAIL_PG),
        .q   (pg_s)
    );

    assign pg_all = &pg_s;

    // Select the current rail's power-good and find the lowest failing rail.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pg_cur  = 1'b0;
        low_idx = '0;
        for (int i = 0; i < NUM_RAILS; i++) begin
            if (IDX_W'(i) == idx) begin
                pg_cur = pg_s[i];
            end
        end
        // Scan downwards so the last hit, the lowest index, wins.
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (!pg_s[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Sequencing FSM: next state, counter, rail index, enables and fault rail.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        en_nxt         = RAIL_EN;
        fault_rail_nxt = FAULT_RAIL;

        case (state)
            ST_IDLE: begin
                en_nxt = '0;
                if (req_s) begin
                    state_nxt = ST_UP_DLY;
                    idx_nxt   = '0;
                    cnt_nxt   = STEP_DLY;
                end
            end

            ST_UP_DLY: begin
                if (!req_s) begin
                    // Abort: rail idx is not yet enabled, so power-down
                    // starts from the rail below it.
                    if (idx == '0) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_DN_DLY;
                        idx_nxt   = idx - IDX_W'(1);
                        cnt_nxt   = STEP_DLY;
                    end
                end else if (cnt == '0) begin
                    for (int i = 0; i < NUM_RAILS; i++) begin
                        if (IDX_W'(i) == idx) begin
                            en_nxt[i] = 1'b1;
                        end
                    end
                    state_nxt = ST_UP_WAIT;
                    cnt_nxt   = PG_TIMEOUT;
                end else begin
                    cnt_nxt = cnt_dec(cnt);
                end
            end

            ST_UP_WAIT: begin
                // Power-good is tested before the timeout so a good arriving
                // on the last counted cycle still counts as success.
                if (pg_cur) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_ON;
                    end else begin
                        state_nxt = ST_UP_DLY;
                        idx_nxt   = idx + IDX_W'(1);
                        cnt_nxt   = STEP_DLY;
                    end
                end else if (cnt == '0) begin
                    state_nxt      = ST_FAULT;
                    en_nxt         = '0;
                    fault_rail_nxt = idx;
                end else if (!req_s) begin
                    // Rail idx is already enabled, so it is the first to go.
                    state_nxt = ST_DN_DLY;
                    cnt_nxt   = STEP_DLY;
                end else begin
                    cnt_nxt = cnt_dec(cnt);
                end
            end

            ST_ON: begin
                // A power-good loss outranks a simultaneous power-down request.
                if (!pg_all) begin
                    state_nxt      = ST_FAULT;
                    en_nxt         = '0;
                    fault_rail_nxt = low_idx;
                end else if (!req_s) begin
                    state_nxt = ST_DN_DLY;
                    idx_nxt   = LAST_IDX;
                    cnt_nxt   = STEP_DLY;
                end
            end

            ST_DN_DLY: begin
                // A renewed request is ignored here; IDLE picks it up once
                // every rail is off.
                if (cnt == '0) begin
                    for (int i = 0; i < NUM_RAILS; i++) begin
                        if (IDX_W'(i) == idx) begin
                            en_nxt[i] = 1'b0;
                        end
                    end
                    if (idx == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx - IDX_W'(1);
                        cnt_nxt = STEP_DLY;
                    end
                end else begin
                    cnt_nxt = cnt_dec(cnt);
                end
            end

            ST_FAULT: begin
                en_nxt = '0;
                if (!req_s) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                en_nxt    = '0;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // State and output registers; status flags decode the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            RAIL_EN    <= '0;
            SEQ_DONE   <= 1'b0;
            SEQ_FAULT  <= 1'b0;
            FAULT_RAIL <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            RAIL_EN    <= en_nxt;
            SEQ_DONE   <= (state_nxt == ST_ON);
            SEQ_FAULT  <= (state_nxt == ST_FAULT);
            FAULT_RAIL <= fault_rail_nxt;
        end
    end

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Directed bench for power_seq_ctrl with a small power-good responder.
// Expected RAIL_EN steps are queued as stimulus is applied and popped as
// the DUT changes its enables.
module tb_power_seq_ctrl;

    localparam int STEP = 4;

    logic       SYSCLK;
    logic       RESET;
    logic       PWR_ON_REQ;
    logic [3:0] RAIL_PG;
    logic [3:0] RAIL_EN;
    logic       SEQ_DONE;
    logic       SEQ_FAULT;
    logic [2:0] FAULT_RAIL;

    logic [3:0] pg_model;   // responder output: good 2 cycles after enable
    logic [3:0] pg_kill;    // forces chosen power-good bits low
    logic [3:0] prev_en;
    logic [3:0] exp_q[$];
    int         n_cmp;
    int         n_err;
    int         el;

    assign RAIL_PG = pg_model & ~pg_kill;

    power_seq_ctrl #(
        .NUM_RAILS  (4),
        .STEP_DLY   (16'd4),
        .PG_TIMEOUT (16'd8)
    ) dut (
        .SYSCLK     (SYSCLK),
        .RESET      (RESET),
        .PWR_ON_REQ (PWR_ON_REQ),
        .RAIL_PG    (RAIL_PG),
        .RAIL_EN    (RAIL_EN),
        .SEQ_DONE   (SEQ_DONE),
        .SEQ_FAULT  (SEQ_FAULT),
        .FAULT_RAIL (FAULT_RAIL)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    // Power-good responder: a rail reports good 2 cycles after its enable
    // rises and drops as soon as the enable is removed.
    initial begin
        int age[4];
        pg_model = '0;
        for (int i = 0; i < 4; i++) age[i] = 0;
        forever begin
            @(posedge SYSCLK);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (!RAIL_EN[i]) begin
                    age[i]      = 0;
                    pg_model[i] = 1'b0;
                end else if (age[i] == 2) begin
                    pg_model[i] = 1'b1;
                end else begin
                    age[i] = age[i] + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for RAIL_EN to change, then compare against the
    // oldest queued expectation. el returns the cycles waited.
    task automatic next_en(input string tag, input int bound, output int cycles);
        logic [3:0] exp;
        bit         seen;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < bound) begin
            step();
            cycles++;
            if (RAIL_EN !== prev_en) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
        check(tag, 32'(RAIL_EN), 32'(exp));
        prev_en = RAIL_EN;
    endtask

    // Wait (bounded) for SEQ_DONE (sel=0) or SEQ_FAULT (sel=1) to reach val.
    task automatic wait_flag(input string tag, input bit sel, input logic val, input int bound);
        int n;
        n = 0;
        while (((sel ? SEQ_FAULT : SEQ_DONE) !== val) && n < bound) begin
            step();
            n++;
        end
        check(tag, 32'(sel ? SEQ_FAULT : SEQ_DONE), 32'(val));
    endtask

    task automatic power_up_to_on(input string tag);
        PWR_ON_REQ = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b1111);
        next_en({tag, "_en0"}, 30, el);
        next_en({tag, "_en1"}, 30, el);
        next_en({tag, "_en2"}, 30, el);
        next_en({tag, "_en3"}, 30, el);
        wait_flag({tag, "_done"}, 1'b0, 1'b1, 20);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        pg_kill    = '0;
        prev_en    = '0;
        PWR_ON_REQ = 1'b0;
        RESET      = 1'b1;

        // Reset state before any clock edge.
        #3;
        check("rst_en",    32'(RAIL_EN),    32'd0);
        check("rst_done",  32'(SEQ_DONE),   32'd0);
        check("rst_fault", 32'(SEQ_FAULT),  32'd0);
        check("rst_frail", 32'(FAULT_RAIL), 32'd0);
        step();
        step();
        RESET = 1'b0;
        step();
        step();
        check("idle_en", 32'(RAIL_EN), 32'd0);

        // Normal power-up with exact latencies: request driven just after an
        // edge is sampled on the next edge; EN[0] follows STEP+3 edges later.
        PWR_ON_REQ = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b1111);
        next_en("up_en0", 30, el);
        check("up_lat_en0", 32'(el), 32'(STEP + 4));
        next_en("up_en1", 30, el);
        // PG good 2 cycles after EN, then 1 sample edge + STEP+3 edges.
        check("up_pg_to_en1", 32'(el), 32'(STEP + 6));
        next_en("up_en2", 30, el);
        next_en("up_en3", 30, el);
        wait_flag("up_done", 1'b0, 1'b1, 20);
        check("up_no_fault", 32'(SEQ_FAULT), 32'd0);

        // Normal power-down: reverse order, STEP+1 cycles apart.
        PWR_ON_REQ = 1'b0;
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        wait_flag("dn_done_drop", 1'b0, 1'b0, 10);
        next_en("dn_en3", 30, el);
        check("dn_gap3", 32'(el), 32'(STEP + 1));
        next_en("dn_en2", 30, el);
        check("dn_gap2", 32'(el), 32'(STEP + 1));
        next_en("dn_en1", 30, el);
        check("dn_gap1", 32'(el), 32'(STEP + 1));
        next_en("dn_en0", 30, el);
        check("dn_gap0", 32'(el), 32'(STEP + 1));
        repeat (5) step();
        check("dn_idle_en", 32'(RAIL_EN), 32'd0);

        // Power-good timeout on rail 2.
        pg_kill    = 4'b0100;
        PWR_ON_REQ = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0000);
        next_en("to_en0", 30, el);
        next_en("to_en1", 30, el);
        next_en("to_en2", 30, el);
        next_en("to_clear", 30, el);
        check("to_window", 32'(el >= 8 && el <= 9), 32'd1);
        check("to_fault",  32'(SEQ_FAULT),  32'd1);
        check("to_frail",  32'(FAULT_RAIL), 32'd2);
        check("to_done",   32'(SEQ_DONE),   32'd0);
        repeat (10) step();
        check("to_hold_fault", 32'(SEQ_FAULT), 32'd1);
        check("to_hold_en",    32'(RAIL_EN),   32'd0);
        PWR_ON_REQ = 1'b0;
        pg_kill    = '0;
        wait_flag("to_exit", 1'b1, 1'b0, 10);
        check("to_frail_held", 32'(FAULT_RAIL), 32'd2);

        // Single-cycle PG loss on rail 1 while ON.
        power_up_to_on("loss1");
        exp_q.push_back(4'b0000);
        pg_kill = 4'b0010;
        step();
        pg_kill = '0;
        next_en("loss1_clear", 10, el);
        check("loss1_lat",   32'(el),         32'd2);
        check("loss1_fault", 32'(SEQ_FAULT),  32'd1);
        check("loss1_frail", 32'(FAULT_RAIL), 32'd1);
        check("loss1_done",  32'(SEQ_DONE),   32'd0);
        PWR_ON_REQ = 1'b0;
        wait_flag("loss1_exit", 1'b1, 1'b0, 10);

        // Rails 1 and 3 lost together: the lowest one is reported.
        power_up_to_on("loss13");
        exp_q.push_back(4'b0000);
        pg_kill = 4'b1010;
        step();
        pg_kill = '0;
        next_en("loss13_clear", 10, el);
        check("loss13_frail", 32'(FAULT_RAIL), 32'd1);
        PWR_ON_REQ = 1'b0;
        wait_flag("loss13_exit", 1'b1, 1'b0, 10);

        // Abort during the step delay before rail 2.
        PWR_ON_REQ = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        next_en("ab_en0", 30, el);
        next_en("ab_en1", 30, el);
        repeat (5) step();
        PWR_ON_REQ = 1'b0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        next_en("ab_dn1", 30, el);
        next_en("ab_dn0", 30, el);
        check("ab_gap", 32'(el), 32'(STEP + 1));
        check("ab_done", 32'(SEQ_DONE), 32'd0);

        // Asynchronous reset while waiting for rail 1's power-good.
        PWR_ON_REQ = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        next_en("rs_en0", 30, el);
        next_en("rs_en1", 30, el);
        #2;
        RESET = 1'b1;
        #1;
        check("rs_en",    32'(RAIL_EN),    32'd0);
        check("rs_done",  32'(SEQ_DONE),   32'd0);
        check("rs_fault", 32'(SEQ_FAULT),  32'd0);
        check("rs_frail", 32'(FAULT_RAIL), 32'd0);
        step();
        step();
        RESET   = 1'b0;
        prev_en = 4'b0000;
        exp_q.push_back(4'b0001);
        next_en("rs_restart", 30, el);
        check("rs_restart_lat", 32'(el), 32'(STEP + 4));
        check("rs_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
